// File: rtl/sdhci_pkg.sv
// Shared SD host definitions: frequency-select width, half-period limit and
// clock-monitor state encoding.
package sdhci_pkg;

  localparam int unsigned SdFreqW       = 10;
  localparam int unsigned MaxHalfPeriod = 2046;

  typedef enum logic [2:0] {
    MON_IDLE    = 3'd0,
    MON_ACQUIRE = 3'd1,
    MON_MEASURE = 3'd2,
    MON_LOCKED  = 3'd3,
    MON_STOPPED = 3'd4
  } mon_state_e;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module prim_flop_2sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] s1_q;
  logic [Width-1:0] s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/sd_clk_edge_detect.sv
// Synchronizes SDCLK into clk_i, detects edges against a delayed copy and
// registers one-cycle rise/fall strobes.
module sd_clk_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sdclk_i,
  output logic level_o,
  output logic edge_c,
  output logic rise_o,
  output logic fall_o
);

  logic rst_n;
  logic s2;
  logic s3_d, s3_q;
  logic rise_d, rise_q;
  logic fall_d, fall_q;

  assign rst_n = ~rst_i;

  prim_flop_2sync #(
    .Width (1)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_n),
    .d_i    (sdclk_i),
    .q_o    (s2)
  );

  always_comb begin
    s3_d   = s2;
    rise_d = (s2 != s3_q) && s2;
    fall_d = (s2 != s3_q) && !s2;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = s3_q;
  assign edge_c  = s2 ^ s3_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/sd_clock_monitor.sv
// SDCLK receive monitor: edge strobes, half-period measurement, recovered
// frequency select with lock tracking, and stop / irregular-period detection.
module sd_clock_monitor
  import sdhci_pkg::*;
#(
  parameter int unsigned CntW       = 12,
  parameter int unsigned StopCycles = 4096
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sdclk_i,
  input  logic               enable_i,
  output logic               rise_o,
  output logic               fall_o,
  output logic [SdFreqW-1:0] freq_o,
  output logic               freq_valid_o,
  output logic               glitch_o,
  output logic               stopped_o,
  output logic               stopped_high_o
);

  localparam int unsigned     HW         = CntW + 1;
  localparam logic [CntW-1:0] CntMax     = '1;
  localparam logic [CntW-1:0] StopThresh = CntW'(StopCycles - 1);

  logic               level;
  logic               edge_c;
  logic [CntW-1:0]    cnt_d, cnt_q;
  logic [HW-1:0]      h_c;
  logic               h_valid_c;
  logic [SdFreqW-1:0] h_freq_c;
  logic               stop_c;
  mon_state_e         state_d, state_q;
  logic [SdFreqW-1:0] cand_d, cand_q;
  logic               cand_vld_d, cand_vld_q;
  logic [SdFreqW-1:0] freq_d, freq_q;
  logic               freq_valid_d, freq_valid_q;
  logic               glitch_d, glitch_q;
  logic               stopped_d, stopped_q;
  logic               stopped_high_d, stopped_high_q;

  sd_clk_edge_detect u_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .sdclk_i (sdclk_i),
    .level_o (level),
    .edge_c  (edge_c),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
  );

  // Cycles since the last edge, saturating; H = 1 maps to freq 0 via the shift.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_c) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign h_c       = {1'b0, cnt_q} + HW'(1);
  assign h_valid_c = (h_c == HW'(1)) || (!h_c[0] && (h_c <= HW'(MaxHalfPeriod)));
  assign h_freq_c  = SdFreqW'(h_c >> 1);
  assign stop_c    = !edge_c && (cnt_d == StopThresh);

  always_comb begin
    state_d        = state_q;
    cand_d         = cand_q;
    cand_vld_d     = cand_vld_q;
    freq_d         = freq_q;
    glitch_d       = 1'b0;
    stopped_high_d = 1'b0;
    if (!enable_i) begin
      state_d    = MON_IDLE;
      freq_d     = '0;
      cand_vld_d = 1'b0;
    end else begin
      case (state_q)
        MON_IDLE: state_d = MON_ACQUIRE;
        MON_ACQUIRE: begin
          if (edge_c) begin
            state_d    = MON_MEASURE;
            cand_vld_d = 1'b0;
          end
        end
        MON_MEASURE: begin
          if (edge_c) begin
            if (!h_valid_c) begin
              glitch_d = 1'b1;
            end else if (cand_vld_q && (h_freq_c == cand_q)) begin
              state_d = MON_LOCKED;
              freq_d  = h_freq_c;
            end else begin
              cand_d     = h_freq_c;
              cand_vld_d = 1'b1;
            end
          end else if (stop_c) begin
            state_d        = MON_STOPPED;
            stopped_high_d = level;
          end
        end
        MON_LOCKED: begin
          if (edge_c) begin
            if (!(h_valid_c && (h_freq_c == freq_q))) begin
              glitch_d   = 1'b1;
              state_d    = MON_MEASURE;
              cand_d     = h_freq_c;
              cand_vld_d = h_valid_c;
            end
          end else if (stop_c) begin
            state_d        = MON_STOPPED;
            stopped_high_d = level;
          end
        end
        MON_STOPPED: begin
          // The edge ending a stop carries a meaningless half-period.
          if (edge_c) begin
            state_d    = MON_MEASURE;
            cand_vld_d = 1'b0;
          end
        end
        default: state_d = MON_IDLE;
      endcase
    end
    freq_valid_d = (state_d == MON_LOCKED);
    stopped_d    = (state_d == MON_STOPPED);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q          <= '0;
      state_q        <= MON_IDLE;
      cand_q         <= '0;
      cand_vld_q     <= 1'b0;
      freq_q         <= '0;
      freq_valid_q   <= 1'b0;
      glitch_q       <= 1'b0;
      stopped_q      <= 1'b0;
      stopped_high_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      cand_q         <= cand_d;
      cand_vld_q     <= cand_vld_d;
      freq_q         <= freq_d;
      freq_valid_q   <= freq_valid_d;
      glitch_q       <= glitch_d;
      stopped_q      <= stopped_d;
      stopped_high_q <= stopped_high_d;
    end
  end

  assign freq_o         = freq_q;
  assign freq_valid_o   = freq_valid_q;
  assign glitch_o       = glitch_q;
  assign stopped_o      = stopped_q;
  assign stopped_high_o = stopped_high_q;

endmodule

// File: tb/tb_sd_clock_monitor.sv
// Bench for sd_clock_monitor: directed SDCLK patterns, an event-level model
// checked every cycle, and literal expectations at the end of each phase.
module tb_sd_clock_monitor;

  localparam int STOP = 4096;
  localparam int M_IDLE = 0, M_ACQ = 1, M_MEAS = 2, M_LOCK = 3, M_STOP = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       sdclk_i;
  logic       enable_i;
  logic       rise_o, fall_o, freq_valid_o, glitch_o, stopped_o, stopped_high_o;
  logic [9:0] freq_o;

  sd_clock_monitor #(
    .CntW       (12),
    .StopCycles (STOP)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .sdclk_i        (sdclk_i),
    .enable_i       (enable_i),
    .rise_o         (rise_o),
    .fall_o         (fall_o),
    .freq_o         (freq_o),
    .freq_valid_o   (freq_valid_o),
    .glitch_o       (glitch_o),
    .stopped_o      (stopped_o),
    .stopped_high_o (stopped_high_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int glitch_seen = 0;
  int sh_seen = 0;

  // Event-level model: the monitor sees the input three clocks late, so an
  // edge is a change between the samples taken two and three clocks ago.
  bit         hist[$];
  int         n_cyc = 0;
  int         last_edge = 0;
  int         mode = M_IDLE;
  int         cand = 0;
  bit         cand_ok = 1'b0;
  int         freq = 0;
  int         h, h_f;
  bit         h_ok, ev, d2, d3;
  bit         e_r, e_f, e_g, e_sh;
  logic [15:0] exp_vec = '0;
  bit         model_ok = 1'b0;

  initial begin
    repeat (4) hist.push_back(1'b0);
    forever begin
      @(posedge clk);
      n_cyc++;
      hist.push_back(rst_i ? 1'b0 : bit'(sdclk_i));
      hist.delete(0);
      d2 = hist[1];
      d3 = hist[0];
      e_r = 1'b0; e_f = 1'b0; e_g = 1'b0; e_sh = 1'b0;
      if (rst_i) begin
        mode = M_IDLE; last_edge = n_cyc; cand = 0; cand_ok = 1'b0; freq = 0;
      end else begin
        ev  = (d2 != d3);
        e_r = ev && d2;
        e_f = ev && !d2;
        h = n_cyc - last_edge;
        if (h > 4096) h = 4096;
        h_ok = (h == 1) || ((h % 2 == 0) && (h <= 2046));
        h_f = h / 2;
        if (!enable_i) begin
          mode = M_IDLE; freq = 0; cand_ok = 1'b0;
        end else begin
          case (mode)
            M_IDLE: mode = M_ACQ;
            M_ACQ:  if (ev) begin mode = M_MEAS; cand_ok = 1'b0; end
            M_MEAS: begin
              if (ev) begin
                if (!h_ok) e_g = 1'b1;
                else if (cand_ok && cand == h_f) begin mode = M_LOCK; freq = h_f; end
                else begin cand = h_f; cand_ok = 1'b1; end
              end else if (n_cyc - last_edge == STOP - 1) begin
                mode = M_STOP; e_sh = d2;
              end
            end
            M_LOCK: begin
              if (ev) begin
                if (!(h_ok && h_f == freq)) begin
                  e_g = 1'b1; mode = M_MEAS; cand = h_f; cand_ok = h_ok;
                end
              end else if (n_cyc - last_edge == STOP - 1) begin
                mode = M_STOP; e_sh = d2;
              end
            end
            M_STOP: if (ev) begin mode = M_MEAS; cand_ok = 1'b0; end
            default: mode = M_IDLE;
          endcase
        end
        if (ev) last_edge = n_cyc;
      end
      exp_vec = {e_r, e_f, mode == M_LOCK, e_g, mode == M_STOP, e_sh, 10'(freq)};
      model_ok = 1'b1;
    end
  end

  function automatic logic [15:0] outvec();
    return {rise_o, fall_o, freq_valid_o, glitch_o, stopped_o, stopped_high_o, freq_o};
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        act = outvec();
        n_cmp++;
        if (act !== exp_vec) begin
          n_bad++;
          $display("FAIL cycle_%0d outputs {rise,fall,valid,glitch,stop,stop_hi,freq}: got %h want %h",
                   n_cyc, act, exp_vec);
        end
        if (glitch_o) glitch_seen++;
        if (stopped_high_o) sh_seen++;
      end
    end
  end

  task automatic check(input string name, input int act, input int want);
    #1;
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic ticks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic half(input int k);
    sdclk_i = ~sdclk_i;
    ticks(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d n_bad %0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; sdclk_i = 1'b0;
    ticks(5);
    check("reset_outputs", int'(outvec()), 0);
    rst_i = 1'b0;
    ticks(3);
    check("idle_no_valid", int'(freq_valid_o), 0);

    // Undivided clock: toggles every cycle.
    enable_i = 1'b1; glitch_seen = 0;
    repeat (24) half(1);
    check("f0_valid", int'(freq_valid_o), 1);
    check("f0_freq", int'(freq_o), 0);
    check("f0_one_strobe", int'(rise_o) + int'(fall_o), 1);
    check("f0_glitches", glitch_seen, 0);

    // freq 5, then switch to 1023.
    glitch_seen = 0;
    repeat (6) half(10);
    check("f5_freq", int'(freq_o), 5);
    check("f5_valid", int'(freq_valid_o), 1);
    check("f5_glitches", glitch_seen, 1);
    glitch_seen = 0;
    repeat (3) half(2046);
    check("f1023_freq", int'(freq_o), 1023);
    check("f1023_valid", int'(freq_valid_o), 1);
    check("f1023_glitches", glitch_seen, 1);

    // Stop low.
    sh_seen = 0;
    half(4200);
    check("stop_low_stopped", int'(stopped_o), 1);
    check("stop_low_valid", int'(freq_valid_o), 0);
    check("stop_low_no_high", sh_seen, 0);

    // Restart at freq 2.
    repeat (6) half(4);
    check("f2_freq", int'(freq_o), 2);
    check("f2_valid", int'(freq_valid_o), 1);
    check("f2_not_stopped", int'(stopped_o), 0);

    // Stop high.
    sh_seen = 0;
    half(4200);
    check("stop_high_stopped", int'(stopped_o), 1);
    check("stop_high_pulses", sh_seen, 1);

    // Lock at freq 4, inject one 3-cycle half-period, relock.
    repeat (4) half(8);
    check("f4_freq", int'(freq_o), 4);
    check("f4_valid", int'(freq_valid_o), 1);
    glitch_seen = 0;
    half(3);
    repeat (3) half(8);
    check("f4_glitches", glitch_seen, 1);
    check("f4_relock_freq", int'(freq_o), 4);
    check("f4_relock_valid", int'(freq_valid_o), 1);

    // Reset while locked with SDCLK high.
    rst_i = 1'b1; enable_i = 1'b0;
    ticks(1);
    check("rst_mid_lock_outputs", int'(outvec()), 0);
    ticks(3);
    rst_i = 1'b0;
    ticks(1); check("post_rst_rise_c1", int'(rise_o), 0);
    ticks(1); check("post_rst_rise_c2", int'(rise_o), 0);
    ticks(1); check("post_rst_rise_c3", int'(rise_o), 1);
    ticks(1); check("post_rst_rise_c4", int'(rise_o), 0);
    ticks(10);
    check("post_rst_idle_valid", int'(freq_valid_o), 0);
    check("post_rst_idle_stopped", int'(stopped_o), 0);
    enable_i = 1'b1;
    repeat (12) half(1);
    check("post_rst_relock_valid", int'(freq_valid_o), 1);
    check("post_rst_relock_freq", int'(freq_o), 0);

    ticks(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
